// File: rtl/rs_frame_tx.sv
// rs_frame_tx: wraps a fixed-length run of 32-bit payload words into a
// self-delimiting packet (sync header, length, payload, XOR checksum) and
// feeds it byte-serially to the RS232C transmitter through its start/status
// handshake. Payload words are buffered in a small FIFO.
module rs_frame_tx #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] HDR0       = 8'hA5,
    parameter logic [7:0] HDR1       = 8'h5A
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_kick,
    input  logic [15:0] frame_words,
    output logic        frame_done,
    output logic        busy,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    output logic        word_ready,
    output logic        rs_tx_start,
    output logic [7:0]  rs_tx_data,
    input  logic        rs_tx_status
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_ACK   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Picks one byte of a payload word, MSB byte first.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            2'd3:    b = w[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t          state_r;
    logic [15:0]     len_r;
    logic [17:0]     idx_r;
    logic [15:0]     wcnt_r;
    logic [7:0]      csum_r;
    logic            last_r;
    logic            busy_r;
    logic            done_r;
    logic            start_r;
    logic [7:0]      data_r;

    logic [31:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wptr_r;
    logic [AW-1:0]   rptr_r;
    logic [AW:0]     cnt_r;

    logic [17:0]     pay_end_s;
    logic            in_payload_s;
    logic            is_csum_s;
    logic            fifo_empty_s;
    logic            fifo_full_s;
    logic            push_s;
    logic            pop_s;
    logic            load_ok_s;
    logic [7:0]      byte_s;

    // Packet position decode; checksum byte index sits right after the payload.
    always_comb begin
        pay_end_s    = {len_r, 2'b00} + 18'd4;
        in_payload_s = (idx_r >= 18'd4) && (idx_r < pay_end_s);
        is_csum_s    = (idx_r == pay_end_s);
        fifo_empty_s = (cnt_r == '0);
        fifo_full_s  = (cnt_r == (AW+1)'(FIFO_DEPTH));
        word_ready   = busy_r & ~fifo_full_s & (wcnt_r < len_r);
        push_s       = word_valid & word_ready;
        load_ok_s    = ~(in_payload_s & fifo_empty_s);
        pop_s        = (state_r == ST_LOAD) & in_payload_s & ~fifo_empty_s & (idx_r[1:0] == 2'd3);
    end

    // Byte to load next, chosen by position within the packet.
    always_comb begin
        byte_s = 8'h00;
        if (idx_r == 18'd0) begin
            byte_s = HDR0;
        end else if (idx_r == 18'd1) begin
            byte_s = HDR1;
        end else if (idx_r == 18'd2) begin
            byte_s = len_r[15:8];
        end else if (idx_r == 18'd3) begin
            byte_s = len_r[7:0];
        end else if (in_payload_s) begin
            byte_s = word_byte(mem_r[rptr_r], idx_r[1:0]);
        end else begin
            byte_s = csum_r;
        end
    end

    // FIFO storage write; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r] <= word_data;
        end
    end

    // FIFO pointers, occupancy and the accepted-word counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cnt_r  <= '0;
            wcnt_r <= 16'd0;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + AW'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
                2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
                default: cnt_r <= cnt_r;
            endcase
            if ((state_r == ST_IDLE) && frame_kick) begin
                wcnt_r <= 16'd0;
            end else if (push_s) begin
                wcnt_r <= wcnt_r + 16'd1;
            end
        end
    end

    // Frame sequencer with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            len_r   <= 16'd0;
            idx_r   <= 18'd0;
            csum_r  <= 8'h00;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            start_r <= 1'b0;
            data_r  <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (frame_kick) begin
                        len_r   <= frame_words;
                        idx_r   <= 18'd0;
                        csum_r  <= 8'h00;
                        last_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (load_ok_s) begin
                        data_r  <= byte_s;
                        start_r <= 1'b1;
                        idx_r   <= idx_r + 18'd1;
                        last_r  <= is_csum_s;
                        if ((idx_r >= 18'd2) && !is_csum_s) begin
                            csum_r <= csum_r ^ byte_s;
                        end
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    start_r <= 1'b0;
                    state_r <= ST_ACK;
                end
                ST_ACK: begin
                    if (rs_tx_status) begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!rs_tx_status) begin
                        if (last_r) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    start_r <= 1'b0;
                end
            endcase
        end
    end

    assign frame_done  = done_r;
    assign busy        = busy_r;
    assign rs_tx_start = start_r;
    assign rs_tx_data  = data_r;

endmodule
